// File: rtl/axis_bram_writer_if.sv
// rtl/axis_bram_writer_if.sv - stream-in / buffer-write bundle for axis_bram_writer
interface axis_bram_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                      S_AXIS_TVALID;
    logic [DATA_WIDTH-1:0]     S_AXIS_TDATA;
    logic [DATA_WIDTH/8-1:0]   S_AXIS_TSTRB;
    logic                      S_AXIS_TLAST;
    logic                      S_AXIS_TREADY;
    logic                      CLEAR;
    logic [ADDR_WIDTH-1:0]     BUF_ADDR;
    logic [DATA_WIDTH-1:0]     BUF_DATA;
    logic [DATA_WIDTH/8-1:0]   BUF_WE;
    logic                      BUF_VALID;
    logic                      BUF_ACCEP;
    logic                      FRAME_DONE;
    logic [ADDR_WIDTH:0]       FRAME_LEN;
    logic                      WRAPPED;

    modport slave (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, CLEAR, BUF_ACCEP,
        output S_AXIS_TREADY, BUF_ADDR, BUF_DATA, BUF_WE, BUF_VALID, FRAME_DONE, FRAME_LEN, WRAPPED
    );

    modport master (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, CLEAR, BUF_ACCEP,
        input  S_AXIS_TREADY, BUF_ADDR, BUF_DATA, BUF_WE, BUF_VALID, FRAME_DONE, FRAME_LEN, WRAPPED
    );
endinterface

// File: rtl/axis_bram_writer.sv
// rtl/axis_bram_writer.sv - AXI-Stream slave buffered through a FWFT FIFO into addressed BRAM writes
module axis_bram_writer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_WIDTH           = 10,
    parameter int FIFO_DEPTH           = 4,
    parameter int BASE_ADDR            = 0,
    parameter int ADDR_MODE            = 0
) (
    input  logic S_AXIS_ACLK,
    input  logic S_AXIS_ARESETN,
    axis_bram_writer_if.slave bus
);
    localparam int DW = C_S_AXIS_TDATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int EW = DW + SW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [PW:0]           FULL_COUNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONES  = '1;
    localparam logic [ADDR_WIDTH:0]   CNT_MAX    = '1;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   frame_cnt;
    logic [ADDR_WIDTH:0]   frame_len;
    logic                  frame_done;
    logic                  wrapped;

    logic [EW-1:0]         head;
    logic                  head_last;
    logic                  push;
    logic                  pop;
    logic                  tready;
    logic                  buf_valid;
    logic [ADDR_WIDTH:0]   cnt_inc;

    assign head      = mem[rd_ptr];
    assign head_last = head[EW-1];
    assign tready    = ready_q && (count != FULL_COUNT);
    assign buf_valid = (count != '0);
    assign push      = bus.S_AXIS_TVALID && tready;
    assign pop       = buf_valid && bus.BUF_ACCEP;
    assign cnt_inc   = (frame_cnt == CNT_MAX) ? CNT_MAX : frame_cnt + 1'b1;

    assign bus.S_AXIS_TREADY = tready;
    assign bus.BUF_VALID     = buf_valid;
    assign bus.BUF_DATA      = head[DW-1:0];
    assign bus.BUF_WE        = buf_valid ? head[DW+SW-1:DW] : '0;
    assign bus.BUF_ADDR      = addr;
    assign bus.FRAME_DONE    = frame_done;
    assign bus.FRAME_LEN     = frame_len;
    assign bus.WRAPPED       = wrapped;

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (push) begin
            mem[wr_ptr] <= {bus.S_AXIS_TLAST, bus.S_AXIS_TSTRB, bus.S_AXIS_TDATA};
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            addr       <= BASE;
            frame_cnt  <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            frame_done <= pop && head_last;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop && head_last) begin
                frame_len <= cnt_inc;
            end

            // CLEAR overrides the address/frame bookkeeping of a coincident pop.
            if (bus.CLEAR) begin
                addr      <= BASE;
                frame_cnt <= '0;
                wrapped   <= 1'b0;
            end else if (pop) begin
                frame_cnt <= head_last ? '0 : cnt_inc;
                if (head_last && (ADDR_MODE == 1)) begin
                    addr <= BASE;
                end else begin
                    addr <= addr + 1'b1;
                    if (addr == ADDR_ONES) begin
                        wrapped <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_bram_writer.sv
// tb/tb_axis_bram_writer.sv - randomized and directed bench for axis_bram_writer against a queue model
module tb_axis_bram_writer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic        tlast = 1'b0;
    logic        clear = 1'b0;
    logic        accep = 1'b0;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    beat_t q[$];
    bit    m_rdy = 0;
    bit    last_push = 0;
    int    m_addr[2];
    int    m_ctr[2];
    int    m_len[2];
    bit    m_fd[2];
    bit    m_wrap[2];
    int    aw[2]   = '{3, 4};
    int    base[2] = '{0, 2};
    int    mode[2] = '{0, 1};

    always #5 clk = ~clk;

    axis_bram_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus0 ();
    axis_bram_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

    assign bus0.S_AXIS_TVALID = tvalid;
    assign bus0.S_AXIS_TDATA  = tdata;
    assign bus0.S_AXIS_TSTRB  = tstrb;
    assign bus0.S_AXIS_TLAST  = tlast;
    assign bus0.CLEAR         = clear;
    assign bus0.BUF_ACCEP     = accep;
    assign bus1.S_AXIS_TVALID = tvalid;
    assign bus1.S_AXIS_TDATA  = tdata;
    assign bus1.S_AXIS_TSTRB  = tstrb;
    assign bus1.S_AXIS_TLAST  = tlast;
    assign bus1.CLEAR         = clear;
    assign bus1.BUF_ACCEP     = accep;

    axis_bram_writer #(
        .C_S_AXIS_TDATA_WIDTH(32), .ADDR_WIDTH(3), .FIFO_DEPTH(4), .BASE_ADDR(0), .ADDR_MODE(0)
    ) dut0 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(resetn), .bus(bus0.slave)
    );

    axis_bram_writer #(
        .C_S_AXIS_TDATA_WIDTH(32), .ADDR_WIDTH(4), .FIFO_DEPTH(4), .BASE_ADDR(2), .ADDR_MODE(1)
    ) dut1 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(resetn), .bus(bus1.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_dut(input int d, input logic rdy, input logic valid, input logic [31:0] data,
                             input logic [3:0] we, input logic [7:0] addr, input logic fd,
                             input logic [7:0] len, input logic wrap);
        bit nonempty;
        nonempty = (q.size() != 0);
        check($sformatf("d%0d_tready", d), rdy, m_rdy && (q.size() != 4));
        check($sformatf("d%0d_buf_valid", d), valid, nonempty);
        check($sformatf("d%0d_buf_addr", d), addr, m_addr[d]);
        if (nonempty) begin
            check($sformatf("d%0d_buf_data", d), data, q[0].data);
            check($sformatf("d%0d_buf_we", d), we, q[0].strb);
        end else begin
            check($sformatf("d%0d_buf_we_idle", d), we, 4'b0000);
        end
        check($sformatf("d%0d_frame_done", d), fd, m_fd[d]);
        check($sformatf("d%0d_frame_len", d), len, m_len[d]);
        check($sformatf("d%0d_wrapped", d), wrap, m_wrap[d]);
    endtask

    task automatic cycle();
        bit push, pop;
        beat_t b;
        int cmax, amax;
        @(negedge clk);
        check_dut(0, bus0.S_AXIS_TREADY, bus0.BUF_VALID, bus0.BUF_DATA, bus0.BUF_WE,
                  {5'b0, bus0.BUF_ADDR}, bus0.FRAME_DONE, {4'b0, bus0.FRAME_LEN}, bus0.WRAPPED);
        check_dut(1, bus1.S_AXIS_TREADY, bus1.BUF_VALID, bus1.BUF_DATA, bus1.BUF_WE,
                  {4'b0, bus1.BUF_ADDR}, bus1.FRAME_DONE, {3'b0, bus1.FRAME_LEN}, bus1.WRAPPED);
        push = tvalid && m_rdy && (q.size() != 4);
        pop  = (q.size() != 0) && accep;
        last_push = 0;
        if (!resetn) begin
            q.delete();
            m_rdy = 0;
            for (int d = 0; d < 2; d++) begin
                m_addr[d] = base[d]; m_ctr[d] = 0; m_len[d] = 0; m_fd[d] = 0; m_wrap[d] = 0;
            end
        end else begin
            m_rdy = 1;
            last_push = push;
            if (pop) b = q.pop_front();
            for (int d = 0; d < 2; d++) begin
                cmax = (1 << (aw[d] + 1)) - 1;
                amax = (1 << aw[d]) - 1;
                m_fd[d] = pop && b.last;
                if (pop && b.last) m_len[d] = (m_ctr[d] + 1 > cmax) ? cmax : m_ctr[d] + 1;
                if (clear) begin
                    m_addr[d] = base[d]; m_ctr[d] = 0; m_wrap[d] = 0;
                end else if (pop) begin
                    m_ctr[d] = b.last ? 0 : ((m_ctr[d] + 1 > cmax) ? cmax : m_ctr[d] + 1);
                    if (b.last && mode[d] == 1) begin
                        m_addr[d] = base[d];
                    end else begin
                        if (m_addr[d] == amax) m_wrap[d] = 1;
                        m_addr[d] = (m_addr[d] + 1) % (amax + 1);
                    end
                end
            end
            if (push) q.push_back('{data: tdata, strb: tstrb, last: tlast});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        tvalid = 1'b1; tdata = data; tstrb = strb; tlast = last;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (last_push) break;
        end
        if (!last_push) check("send_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = base[d]; m_ctr[d] = 0; m_len[d] = 0; m_fd[d] = 0; m_wrap[d] = 0;
        end
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // basic 6-beat frame with downstream always ready
        resetn = 1'b1; accep = 1'b1;
        for (int i = 0; i < 6; i++) send(i, 4'hf, i == 5);
        tvalid = 1'b0;
        repeat (4) cycle();

        // downstream stall fills the FIFO, then drains
        accep = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h100 + i, 4'hf, 1'b0);
        tdata = 32'h104; tlast = 1'b0;
        repeat (4) cycle();
        accep = 1'b1;
        for (int i = 4; i < 8; i++) send(32'h100 + i, (i == 6) ? 4'b0101 : 4'hf, i == 7);
        tvalid = 1'b0;
        repeat (6) cycle();

        // long frame saturates the 3-bit-address instance's length counter
        for (int i = 0; i < 18; i++) send(32'h200 + i, 4'hf, i == 17);
        tvalid = 1'b0;
        repeat (6) cycle();

        // wrap: clear then a 10-beat frame, then two 3-beat frames
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 10; i++) send(32'h300 + i, 4'hf, i == 9);
        for (int i = 0; i < 6; i++) send(32'h400 + i, 4'hf, (i % 3) == 2);
        tvalid = 1'b0;
        repeat (6) cycle();

        // CLEAR coincident with a TLAST pop at address 5
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 10; i++) send(32'h500 + i, 4'hf, i == 9);
        tvalid = 1'b0;
        repeat (5) cycle();
        accep = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h600 + i, 4'hf, i == 3);
        tvalid = 1'b0;
        accep = 1'b1;
        repeat (3) cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        repeat (3) cycle();

        // reset mid-frame with 3 beats buffered
        accep = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h700 + i, 4'hf, 1'b0);
        tvalid = 1'b0;
        resetn = 1'b0;
        repeat (2) cycle();
        resetn = 1'b1; accep = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h800 + i, 4'hf, i == 3);
        tvalid = 1'b0;
        repeat (4) cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!tvalid || last_push) begin
                tvalid = ($urandom % 4) != 0;
                tdata  = $urandom;
                tstrb  = 4'($urandom);
                tlast  = ($urandom % 6) == 0;
            end
            accep = ($urandom % 3) != 0;
            clear = ($urandom % 50) == 0;
            cycle();
        end
        tvalid = 1'b0; clear = 1'b0; accep = 1'b1;
        repeat (6) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
